aes_key_expander: RTL and testbench
===================================

AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, number of round keys generated after the cipher key (legal range 1..10).
REQ-002 SHALL have parameter WDOG_CYCLES, default 15, maximum cycles spent waiting for ks_ready_i per round (used only with REQ-029).
REQ-003 SHALL have a single clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load_i  input  1  request to expand key_i; sampled only in IDLE.
REQ-006 key_i  input  128  cipher key, captured on an accepted load_i.
REQ-007 ks_start_o  output  1  one-cycle start pulse to the key-schedule stage.
REQ-008 ks_round_o  output  4  round number for the key-schedule stage (rcon select).
REQ-009 ks_last_key_o  output  128  previous round key, registered and held stable for the whole round.
REQ-010 ks_new_key_i  input  128  new round key from the key-schedule stage.
REQ-011 ks_ready_i  input  1  one-cycle pulse marking ks_new_key_i valid.
REQ-012 rk_addr_i  input  4  round-key read address.
REQ-013 rk_data_o  output  128  round key at rk_addr_i; combinational read.
REQ-014 busy_o  output  1  expansion in progress.
REQ-015 keys_valid_o  output  1  all round keys 0..NUM_ROUNDS valid.
REQ-016 done_o  output  1  one-cycle pulse on completion.
REQ-017 error_o  output  1  watchdog error, sticky until the next accepted load.

Function
REQ-018 SHALL use the FSM states IDLE, START, WAIT and DONE.
REQ-019 IDLE with load_i=1 SHALL: write key_i to rk[0] and to ks_last_key_o, set round=1, clear keys_valid_o and error_o, and go to START.
REQ-020 START SHALL assert ks_start_o for exactly one cycle with ks_round_o=round, then go to WAIT.
REQ-021 WAIT SHALL hold ks_start_o=0 and ks_last_key_o constant until ks_ready_i=1; on that cycle it SHALL capture ks_new_key_i into rk[round] and into ks_last_key_o.
- If round==NUM_ROUNDS, go to DONE.
- Otherwise increment round and go to START.
REQ-022 DONE SHALL pulse done_o, set keys_valid_o=1 and return to IDLE.
REQ-023 Timing with a 5-cycle key-schedule stage:
- 6 cycles per round.
- done_o asserted 1+6*NUM_ROUNDS cycles after the load cycle (61 at default).
REQ-024 busy_o SHALL be 1 in START, WAIT and DONE, and 0 in IDLE.
REQ-025 load_i while busy_o=1 SHALL be ignored; ks_ready_i outside WAIT SHALL be ignored.
REQ-026 rk_addr_i > NUM_ROUNDS SHALL return all-zero data; reads are permitted at any time and return current register contents.

Reset
REQ-027 Reset SHALL force IDLE, round=0, all rk entries and ks_last_key_o to 0, and ks_start_o, busy_o, keys_valid_o, done_o and error_o to 0.
- Reset mid-expansion aborts the expansion with no partial valid indication.
REQ-028 ks_round_o SHALL reset to 0.

Configuration
REQ-029 With AES_KEYEXP_WATCHDOG_EN defined, a counter cleared on entry to WAIT SHALL, on reaching WAIT_CYCLES... specifically WDOG_CYCLES without ks_ready_i, set error_o=1 and go to IDLE with keys_valid_o=0.
REQ-030 Without AES_KEYEXP_WATCHDOG_EN, error_o SHALL be tied to 0, no counter logic SHALL be present, and WAIT SHALL wait indefinitely.

Structure
REQ-031 A shared package aes_pkg SHALL hold AES_KEY_W=128, AES_NUM_ROUNDS=10 and the FSM state typedef.
REQ-032 Round-key storage SHALL be a sub-module aes_rk_store: 11x128 registers, one write port, one combinational read port, reset-to-zero.

Verification
REQ-033 Load key 2b7e151628aed2a6abf7158809cf4f3c with the key-schedule stage attached:
- rk[1] = a0fafe1788542cb123a339392a6c7605.
- rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
- done_o at cycle 61.
REQ-034 Hold load_i high throughout an expansion: exactly one expansion occurs, and ks_start_o pulses exactly 10 times.
REQ-035 Assert reset at cycle 30 of an expansion: all outputs are 0 immediately; a new load completes normally.
REQ-036 Inject a spurious ks_ready_i in IDLE and in START: no rk write occurs and the round does not change.
REQ-037 With AES_KEYEXP_WATCHDOG_EN, suppress ks_ready_i: error_o=1 at cycle WDOG_CYCLES of WAIT, FSM returns to IDLE, keys_valid_o=0.
REQ-038 Read rk_addr_i=11 and rk_addr_i=15 after completion: rk_data_o = 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-expansion constants and the expander FSM state type.
package aes_pkg;

    localparam int AES_KEY_W      = 128;
    localparam int AES_NUM_ROUNDS = 10;
    localparam int AES_RK_DEPTH   = AES_NUM_ROUNDS + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } kexp_state_e;

endpackage

// File: rtl/aes_rk_store.sv
// Round-key register file: one synchronous write port, one combinational read port,
// all entries cleared by reset.
module aes_rk_store
    import aes_pkg::*;
#(
    parameter int DEPTH = AES_RK_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr_en,
    input  logic [3:0]           i_wr_addr,
    input  logic [AES_KEY_W-1:0] i_wr_data,
    input  logic [3:0]           i_rd_addr,
    output logic [AES_KEY_W-1:0] o_rd_data
);

    localparam logic [3:0] DEPTH_W = 4'(DEPTH);

    logic [AES_KEY_W-1:0] r_rk [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rk[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr < DEPTH_W)) begin
            r_rk[i_wr_addr] <= i_wr_data;
        end
    end

    // Addresses past the physical depth read as zero rather than aliasing.
    assign o_rd_data = (i_rd_addr < DEPTH_W) ? r_rk[i_rd_addr] : '0;

endmodule

// File: rtl/aes_key_expander.sv
// AES-128 key expansion sequencer driving an external key-schedule stage.
// Optional wait watchdog enabled by defining AES_KEYEXP_WATCHDOG_EN.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS  = 10,
    parameter int WDOG_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic [AES_KEY_W-1:0] key_i,
    output logic                 ks_start_o,
    output logic [3:0]           ks_round_o,
    output logic [AES_KEY_W-1:0] ks_last_key_o,
    input  logic [AES_KEY_W-1:0] ks_new_key_i,
    input  logic                 ks_ready_i,
    input  logic [3:0]           rk_addr_i,
    output logic [AES_KEY_W-1:0] rk_data_o,
    output logic                 busy_o,
    output logic                 keys_valid_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [1:0]           dbg_state_o
);

    if (NUM_ROUNDS < 1 || NUM_ROUNDS > AES_NUM_ROUNDS || WDOG_CYCLES < 1) begin : g_bad_param
        $error("aes_key_expander: NUM_ROUNDS must be 1..10 and WDOG_CYCLES >= 1");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    // Handshake: ks_start_o is a one-cycle request carrying ks_round_o and
    // ks_last_key_o; the stage answers with a one-cycle ks_ready_i qualifying
    // ks_new_key_i. ks_ready_i is honoured only while waiting for that answer.

    kexp_state_e          r_state;
    kexp_state_e          w_next_state;
    logic [3:0]           r_round;
    logic [AES_KEY_W-1:0] r_last_key;
    logic                 r_keys_valid;

    logic                 w_load_acc;
    logic                 w_ready_acc;
    logic                 w_last_round;
    logic                 w_wdog_expire;

    logic                 w_wr_en;
    logic [3:0]           w_wr_addr;
    logic [AES_KEY_W-1:0] w_wr_data;
    logic [AES_KEY_W-1:0] w_rd_data;

    assign w_load_acc   = (r_state == ST_IDLE) && load_i;
    assign w_ready_acc  = (r_state == ST_WAIT) && ks_ready_i;
    assign w_last_round = (r_round == LAST_ROUND);

`ifdef AES_KEYEXP_WATCHDOG_EN
    localparam int             WDW       = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);

    logic [WDW-1:0] r_wdog_cnt;
    logic           r_error;

    // Counts cycles spent in WAIT; any other state clears it, so each round starts fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog_cnt <= '0;
        end else if (r_state != ST_WAIT) begin
            r_wdog_cnt <= '0;
        end else if (r_wdog_cnt != WDOG_LAST) begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
        end
    end

    assign w_wdog_expire = (r_state == ST_WAIT) && !ks_ready_i && (r_wdog_cnt == WDOG_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (w_load_acc) begin
            r_error <= 1'b0;
        end else if (w_wdog_expire) begin
            r_error <= 1'b1;
        end
    end

    assign error_o = r_error;
`else
    assign w_wdog_expire = 1'b0;
    assign error_o       = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (load_i) begin
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (ks_ready_i) begin
                    w_next_state = w_last_round ? ST_DONE : ST_START;
                end else if (w_wdog_expire) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Round number stays at its final value after completion until the next load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_round      <= '0;
            r_last_key   <= '0;
            r_keys_valid <= 1'b0;
        end else begin
            if (w_load_acc) begin
                r_round      <= 4'd1;
                r_last_key   <= key_i;
                r_keys_valid <= 1'b0;
            end else if (w_ready_acc) begin
                r_last_key <= ks_new_key_i;
                if (!w_last_round) begin
                    r_round <= r_round + 4'd1;
                end
            end
            if (r_state == ST_DONE) begin
                r_keys_valid <= 1'b1;
            end
        end
    end

    assign w_wr_en   = w_load_acc || w_ready_acc;
    assign w_wr_addr = w_load_acc ? 4'd0 : r_round;
    assign w_wr_data = w_load_acc ? key_i : ks_new_key_i;

    aes_rk_store #(
        .DEPTH (AES_RK_DEPTH)
    ) u_rk_store (
        .clk       (clk),
        .rst       (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (rk_addr_i),
        .o_rd_data (w_rd_data)
    );

    assign rk_data_o     = (rk_addr_i > LAST_ROUND) ? '0 : w_rd_data;
    assign ks_start_o    = (r_state == ST_START);
    assign ks_round_o    = r_round;
    assign ks_last_key_o = r_last_key;
    assign busy_o        = (r_state != ST_IDLE);
    assign done_o        = (r_state == ST_DONE);
    assign keys_valid_o  = r_keys_valid;
    assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: a modelled 5-cycle key-schedule stage, a scoreboard
// of expected round keys, and a monitor that checks the stage handshake and reads.
module tb_aes_key_expander;

    localparam int NR        = 10;
    localparam int WDOG      = 15;
    localparam int STAGE_LAT = 5;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_i;
    logic [127:0] key_i;
    logic         ks_start_o;
    logic [3:0]   ks_round_o;
    logic [127:0] ks_last_key_o;
    logic [127:0] ks_new_key_i;
    logic         ks_ready_i;
    logic [3:0]   rk_addr_i;
    logic [127:0] rk_data_o;
    logic         busy_o;
    logic         keys_valid_o;
    logic         done_o;
    logic         error_o;
    logic [1:0]   dbg_state_o;

    aes_key_expander #(
        .NUM_ROUNDS  (NR),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load_i        (load_i),
        .key_i         (key_i),
        .ks_start_o    (ks_start_o),
        .ks_round_o    (ks_round_o),
        .ks_last_key_o (ks_last_key_o),
        .ks_new_key_i  (ks_new_key_i),
        .ks_ready_i    (ks_ready_i),
        .rk_addr_i     (rk_addr_i),
        .rk_data_o     (rk_data_o),
        .busy_o        (busy_o),
        .keys_valid_o  (keys_valid_o),
        .done_o        (done_o),
        .error_o       (error_o),
        .dbg_state_o   (dbg_state_o)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int errors = 0;
    int checks = 0;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] next_key(input logic [127:0] prev, input logic [3:0] rnd);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 1; i < int'(rnd); i++) rcon = gmul(rcon, 8'h02);
        {w0, w1, w2, w3} = prev;
        t = {w3[23:0], w3[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon;
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q[$];
    int           cyc_q[$];
    logic [127:0] last_exp [NR+1];

    task automatic push_expected(input logic [127:0] k);
        logic [127:0] rk;
        rk = k;
        for (int r = 0; r <= NR; r++) begin
            last_exp[r] = rk;
            rk = next_key(rk, 4'(r + 1));
        end
        if (k == FIPS_KEY) begin
            last_exp[1]  = FIPS_RK1;
            last_exp[NR] = FIPS_RK10;
        end
        for (int r = 0; r <= NR; r++) exp_q.push_back(last_exp[r]);
    endtask

    // ---------------- key-schedule stage model ----------------
    logic         stage_ready = 1'b0;
    logic [127:0] stage_key = '0;
    logic         spur_ready = 1'b0;
    logic [127:0] spur_key = '0;
    bit           stage_mute = 1'b0;
    int           gen = 0;

    assign ks_ready_i   = stage_ready | spur_ready;
    assign ks_new_key_i = stage_ready ? stage_key : spur_key;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (ks_start_o && !reset) begin : stage_round
                int           my_gen;
                logic [127:0] held;
                logic [3:0]   rnd;
                my_gen = gen;
                held   = ks_last_key_o;
                rnd    = ks_round_o;
                repeat (STAGE_LAT) @(posedge clk);
                #1;
                if (my_gen == gen && !stage_mute && !reset) begin
                    check("ks_last_key_stable", ks_last_key_o, held);
                    stage_key   = next_key(held, rnd);
                    stage_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    stage_ready = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    bit mon_busy = 1'b0;
    bit sweep_req = 1'b0;
    int start_cnt = 0;

    initial begin
        rk_addr_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset || !busy_o) start_cnt = 0;
            if (!reset && ks_start_o) begin
                start_cnt++;
                check("ks_round", 128'(ks_round_o), 128'(start_cnt));
                if (exp_q.size() > start_cnt - 1)
                    check("ks_last_key_at_start", ks_last_key_o, exp_q[start_cnt-1]);
            end
            if (!reset && (done_o || sweep_req)) begin
                mon_busy = 1'b1;
                if (done_o) begin
                    if (cyc_q.size() == 0) begin
                        check("done_unexpected", 128'(1), 128'(0));
                    end else begin
                        check("done_latency", 128'(cycle - cyc_q.pop_front()), 128'(1 + 6 * NR));
                    end
                    check("start_pulses", 128'(start_cnt), 128'(NR));
                    tick(1);
                    check("keys_valid_after_done", 128'(keys_valid_o), 128'(1));
                    check("busy_after_done", 128'(busy_o), 128'(0));
                    check("done_one_cycle", 128'(done_o), 128'(0));
                    check("error_after_done", 128'(error_o), 128'(0));
                end
                sweep_req = 1'b0;
                for (int a = 0; a < 16; a++) begin
                    logic [127:0] e;
                    rk_addr_i = 4'(a);
                    #1;
                    if (a <= NR) begin
                        if (exp_q.size() == 0) begin
                            e = ~rk_data_o;
                            $display("FAIL scoreboard_empty: no expected key for addr %0d", a);
                        end else begin
                            e = exp_q.pop_front();
                        end
                    end else begin
                        e = '0;
                    end
                    check($sformatf("rk_read[%0d]", a), rk_data_o, e);
                end
                rk_addr_i = '0;
                mon_busy  = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_load(input logic [127:0] k);
        push_expected(k);
        cyc_q.push_back(cycle);
        load_i = 1'b1;
        key_i  = k;
        tick(1);
        load_i = 1'b0;
        key_i  = rand128();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done_o && n < 200) begin
            tick(1);
            n++;
        end
        if (!done_o) begin
            check("done_timeout", 128'(0), 128'(1));
        end
        load_i = 1'b0;
        n = 0;
        tick(1);
        while ((mon_busy || sweep_req) && n < 100) begin
            tick(1);
            n++;
        end
    endtask

    task automatic request_sweep();
        int n;
        for (int r = 0; r <= NR; r++) exp_q.push_back(last_exp[r]);
        sweep_req = 1'b1;
        n = 0;
        tick(1);
        while ((mon_busy || sweep_req) && n < 100) begin
            tick(1);
            n++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] k;
        int           n;
        build_sbox();
        reset  = 1'b1;
        load_i = 1'b0;
        key_i  = '0;
        tick(2);
        check("rst_busy", 128'(busy_o), 128'(0));
        check("rst_start", 128'(ks_start_o), 128'(0));
        check("rst_valid", 128'(keys_valid_o), 128'(0));
        check("rst_done", 128'(done_o), 128'(0));
        check("rst_error", 128'(error_o), 128'(0));
        check("rst_round", 128'(ks_round_o), 128'(0));
        check("rst_last_key", ks_last_key_o, 128'(0));
        check("rst_rk0", rk_data_o, 128'(0));
        reset = 1'b0;
        tick(2);

        do_load(FIPS_KEY);
        wait_done();

        check("idle_round_before", 128'(ks_round_o), 128'(NR));
        spur_key   = rand128();
        spur_ready = 1'b1;
        tick(1);
        spur_ready = 1'b0;
        tick(1);
        check("idle_round_after", 128'(ks_round_o), 128'(NR));
        check("idle_spur_busy", 128'(busy_o), 128'(0));
        check("idle_spur_valid", 128'(keys_valid_o), 128'(1));
        request_sweep();

        for (int i = 0; i < 4; i++) begin
            tick($urandom_range(0, 3));
            do_load(rand128());
            wait_done();
        end

        k = rand128();
        push_expected(k);
        cyc_q.push_back(cycle);
        load_i = 1'b1;
        key_i  = k;
        tick(1);
        key_i = rand128();
        wait_done();
        tick(2);
        check("hold_load_single", 128'(busy_o), 128'(0));

        do_load(rand128());
        n = 0;
        while (!(ks_start_o && ks_round_o == 4'd3) && n < 100) begin
            tick(1);
            n++;
        end
        check("start_r3_seen", 128'(ks_start_o), 128'(1));
        spur_key   = rand128();
        spur_ready = 1'b1;
        tick(1);
        spur_ready = 1'b0;
        wait_done();

        do_load(rand128());
        tick(28);
        @(posedge clk);
        #2;
        reset = 1'b1;
        gen++;
        #1;
        check("midrst_busy", 128'(busy_o), 128'(0));
        check("midrst_start", 128'(ks_start_o), 128'(0));
        check("midrst_valid", 128'(keys_valid_o), 128'(0));
        check("midrst_done", 128'(done_o), 128'(0));
        check("midrst_error", 128'(error_o), 128'(0));
        check("midrst_round", 128'(ks_round_o), 128'(0));
        check("midrst_last_key", ks_last_key_o, 128'(0));
        check("midrst_rk0", rk_data_o, 128'(0));
        exp_q.delete();
        cyc_q.delete();
        @(posedge clk);
        #1;
        tick(1);
        reset = 1'b0;
        tick(1);
        do_load(rand128());
        wait_done();

`ifdef AES_KEYEXP_WATCHDOG_EN
        begin : wdog_test
            int s;
            stage_mute = 1'b1;
            load_i = 1'b1;
            key_i  = rand128();
            tick(1);
            load_i = 1'b0;
            n = 0;
            while (!ks_start_o && n < 10) begin
                tick(1);
                n++;
            end
            s = cycle;
            n = 0;
            while (!error_o && n < 100) begin
                tick(1);
                n++;
            end
            check("wdog_latency", 128'(cycle - s), 128'(WDOG + 1));
            check("wdog_error", 128'(error_o), 128'(1));
            check("wdog_idle", 128'(busy_o), 128'(0));
            check("wdog_valid", 128'(keys_valid_o), 128'(0));
            tick(3);
            check("wdog_sticky", 128'(error_o), 128'(1));
            stage_mute = 1'b0;
            tick(8);
            do_load(rand128());
            wait_done();
        end
`endif

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
